// File: rtl/mc10_video_fetch_pkg.sv
// Shared definitions for the MC-10 video fetch arbiter: FSM states,
// default address map and the bit layout of the VDG mode latch byte.
package mc10_video_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VRD_A = 3'd1,
        ST_VRD_D = 3'd2,
        ST_CRD_A = 3'd3,
        ST_CRD_D = 3'd4,
        ST_CWR   = 3'd5
    } state_e;

    localparam logic [15:0] DEF_RAM_BASE  = 16'h4000;
    localparam logic [15:0] DEF_MODE_ADDR = 16'hBFFF;
    localparam int          RAM_BYTES     = 8192;

    // Bit positions inside the byte written to the mode latch
    localparam int AN_G   = 5;
    localparam int CSS    = 6;
    localparam int GM_LSB = 2;

    // Extract the three graphics-mode bits from a mode latch byte
    function automatic logic [2:0] mode_gm(input logic [7:0] d);
        return d[GM_LSB +: 3];
    endfunction

endpackage

// File: rtl/mc10_mode_latch.sv
// Write-only VDG mode latch: holds an_g, css and gm, loaded from a CPU byte.
module mc10_mode_latch
    import mc10_video_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic       an_g,
    output logic       css,
    output logic [2:0] gm
);

    // Load the mode fields when the arbiter accepts a write to the latch address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_g <= 1'b0;
            css  <= 1'b0;
            gm   <= 3'b000;
        end else if (we) begin
            an_g <= wdata[AN_G];
            css  <= wdata[CSS];
            gm   <= mode_gm(wdata);
        end
    end

endmodule

// File: rtl/mc10_video_fetch.sv
// Single-port video RAM arbiter for the MC-10: VDG display fetches take
// priority over CPU accesses; CPU accesses outside the RAM window and to the
// mode latch complete in one cycle from IDLE.
//
// CPU handshake: cpu_req is a level held with stable cpu_we/cpu_addr/cpu_wdata
// until cpu_ack; cpu_ack is a single-cycle pulse, cpu_rdata is valid in that
// cycle, and a request still high in the ack cycle is ignored so the CPU can
// drop it on the following edge without being served twice.
module mc10_video_fetch
    import mc10_video_fetch_pkg::*;
#(
    parameter logic [15:0] RAM_BASE  = DEF_RAM_BASE,
    parameter logic [15:0] MODE_ADDR = DEF_MODE_ADDR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdg_req,
    input  logic [12:0] vdg_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  dd,
    output logic        an_s,
    output logic        inv,
    output logic        an_g,
    output logic        css,
    output logic [2:0]  gm,
    output logic        vdg_overrun
);

    localparam logic [15:0] RAM_LAST = RAM_BASE + 16'(RAM_BYTES - 1);

    state_e      state_q;
    state_e      state_d;
    logic        pend_q;
    logic [12:0] pend_addr_q;
    logic        cpu_go;
    logic        cpu_is_mode;
    logic        cpu_in_win;
    logic [12:0] cpu_off;
    logic [12:0] vdg_sel;
    logic        quick_ack;
    logic        mode_we;

    // A request still visible during its own ack cycle is not a new one
    assign cpu_go      = cpu_req && !cpu_ack;
    assign cpu_is_mode = (cpu_addr == MODE_ADDR);
    assign cpu_in_win  = (cpu_addr >= RAM_BASE) && (cpu_addr <= RAM_LAST);
    // Window offset only needs the low 13 bits; the subtraction wraps mod 8 KiB
    assign cpu_off     = cpu_addr[12:0] - RAM_BASE[12:0];
    // A parked display request is older than one arriving now, so it goes first
    assign vdg_sel     = pend_q ? pend_addr_q : vdg_addr;

    assign an_s = dd[7];
    assign inv  = dd[6];

    // Next-state selection and single-cycle CPU completions from IDLE
    always_comb begin
        state_d   = state_q;
        quick_ack = 1'b0;
        mode_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vdg_req || pend_q) begin
                    state_d = ST_VRD_A;
                end else if (cpu_go) begin
                    if (cpu_is_mode || !cpu_in_win) begin
                        quick_ack = 1'b1;
                        mode_we   = cpu_is_mode && cpu_we;
                    end else if (cpu_we) begin
                        state_d = ST_CWR;
                    end else begin
                        state_d = ST_CRD_A;
                    end
                end
            end
            ST_VRD_A: state_d = ST_VRD_D;
            ST_VRD_D: state_d = ST_IDLE;
            ST_CRD_A: state_d = ST_CRD_D;
            ST_CRD_D: state_d = ST_IDLE;
            ST_CWR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM port: address/data registered on entry so they are stable for the whole access state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr  <= 13'd0;
            ram_we    <= 1'b0;
            ram_wdata <= 8'd0;
        end else begin
            ram_we <= (state_d == ST_CWR);
            if (state_q == ST_IDLE) begin
                if (state_d == ST_VRD_A) begin
                    ram_addr <= vdg_sel;
                end else if (state_d == ST_CRD_A) begin
                    ram_addr <= cpu_off;
                end else if (state_d == ST_CWR) begin
                    ram_addr  <= cpu_off;
                    ram_wdata <= cpu_wdata;
                end
            end
        end
    end

    // CPU response: ack pulse plus read data for RAM reads and unmapped/latch reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'd0;
        end else begin
            cpu_ack <= quick_ack || (state_d == ST_CWR) || (state_q == ST_CRD_D);
            if (state_q == ST_CRD_D) begin
                cpu_rdata <= ram_rdata;
            end else if (quick_ack && !cpu_we) begin
                cpu_rdata <= 8'hFF;
            end
        end
    end

    // Display byte captured at the end of the VDG data phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dd <= 8'd0;
        end else if (state_q == ST_VRD_D) begin
            dd <= ram_rdata;
        end
    end

    // One-deep parking slot for display requests that arrive while RAM is busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= 1'b0;
            pend_addr_q <= 13'd0;
            vdg_overrun <= 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (vdg_req) begin
                pend_q      <= 1'b1;
                pend_addr_q <= vdg_addr;
                if (pend_q) begin
                    vdg_overrun <= 1'b1;
                end
            end
        end else if (pend_q) begin
            // Parked request is being issued now; a simultaneous new one takes the slot
            pend_q <= vdg_req;
            if (vdg_req) begin
                pend_addr_q <= vdg_addr;
            end
        end
    end

    mc10_mode_latch u_mode_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mode_we),
        .wdata   (cpu_wdata),
        .an_g    (an_g),
        .css     (css),
        .gm      (gm)
    );

endmodule

// File: tb/tb_mc10_video_fetch.sv
// Bench for mc10_video_fetch: bench-side synchronous RAM, a reference memory
// and expected-completion queue as the model, directed scenarios.
module tb_mc10_video_fetch;

    localparam logic [15:0] RAM_BASE  = 16'h4000;
    localparam logic [15:0] MODE_ADDR = 16'hBFFF;
    localparam logic [1:0]  K_READ    = 2'd0;
    localparam logic [1:0]  K_RAMWR   = 2'd1;
    localparam logic [1:0]  K_MODE    = 2'd2;
    localparam logic [1:0]  K_DROP    = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vdg_req = 1'b0;
    logic [12:0] vdg_addr = 13'd0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  dd;
    logic        an_s;
    logic        inv;
    logic        an_g;
    logic        css;
    logic [2:0]  gm;
    logic        vdg_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected CPU completions in order: {kind, ram offset, data}
    logic [22:0] exp_q[$];
    logic [7:0]  ref_mem [0:8191];
    logic [7:0]  mem     [0:8191];
    logic        ref_ready = 1'b0;
    logic        ram_ready = 1'b0;
    logic [7:0]  exp_mode = 8'd0;
    logic [7:0]  exp_dd = 8'd0;
    logic        prev_ack = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    mc10_video_fetch #(
        .RAM_BASE  (RAM_BASE),
        .MODE_ADDR (MODE_ADDR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vdg_req     (vdg_req),
        .vdg_addr    (vdg_addr),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .dd          (dd),
        .an_s        (an_s),
        .inv         (inv),
        .an_g        (an_g),
        .css         (css),
        .gm          (gm),
        .vdg_overrun (vdg_overrun)
    );

    function automatic logic [7:0] init_byte(input int a);
        logic [31:0] v;
        if (a == 32'h123) return 8'hC5;
        v = a * 7 + 3;
        return v[7:0];
    endfunction

    // Synchronous single-port RAM: read data one cycle after the address
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        logic [22:0] e;
        logic        we_expected;
        if (!ref_ready) begin
            for (int i = 0; i < 8192; i++) ref_mem[i] = init_byte(i);
            ref_ready = 1'b1;
        end else if (!reset_n) begin
            prev_ack = 1'b0;
            exp_mode = 8'd0;
        end else begin
            we_expected = 1'b0;
            chk("an_s_is_dd7", an_s, dd[7]);
            chk("inv_is_dd6", inv, dd[6]);
            if (cpu_ack) begin
                chk("ack_gap", prev_ack, 1'b0);
                if (exp_q.size() == 0) begin
                    fail_now("ack_expected", "cpu_ack with no outstanding request");
                end else begin
                    e = exp_q.pop_front();
                    case (e[22:21])
                        K_READ:  chk("cpu_rdata", cpu_rdata, e[7:0]);
                        K_RAMWR: begin
                            we_expected = 1'b1;
                            chk("wr_ram_we", ram_we, 1'b1);
                            chk("wr_ram_addr", ram_addr, e[20:8]);
                            chk("wr_ram_wdata", ram_wdata, e[7:0]);
                            ref_mem[e[20:8]] = e[7:0];
                        end
                        K_MODE:  exp_mode = e[7:0];
                        default: ;
                    endcase
                end
            end
            if (ram_we && !we_expected) fail_now("ram_we_unexpected", "ram_we outside a RAM write");
            chk("an_g", an_g, exp_mode[5]);
            chk("css", css, exp_mode[6]);
            chk("gm", gm, exp_mode[4:2]);
            prev_ack = cpu_ack;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; dd must update on the third edge.
    task automatic vdg_fetch(input logic [12:0] a);
        logic [7:0] old;
        old = exp_dd;
        vdg_req  = 1'b1;
        vdg_addr = a;
        @(posedge clk); #1;
        vdg_req = 1'b0;
        @(posedge clk); #1;
        chk("dd_not_early", dd, old);
        @(posedge clk); #1;
        exp_dd = ref_mem[a];
        chk("dd_fetch", dd, exp_dd);
    endtask

    // Called just after a rising edge; exp_lat = edges until ack (0 = don't care).
    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d, input int exp_lat);
        logic [1:0]  k;
        logic [7:0]  ed;
        logic [15:0] off;
        int          n;
        logic        got;
        off = a - RAM_BASE;
        if (a == MODE_ADDR) begin
            k  = we ? K_MODE : K_READ;
            ed = we ? d : 8'hFF;
        end else if (a >= 16'h4000 && a <= 16'h5FFF) begin
            k  = we ? K_RAMWR : K_READ;
            ed = we ? d : ref_mem[off[12:0]];
        end else begin
            k  = we ? K_DROP : K_READ;
            ed = we ? d : 8'hFF;
        end
        exp_q.push_back({k, off[12:0], ed});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (cpu_ack) got = 1'b1;
        end
        if (!got) begin
            fail_now("cpu_ack_timeout", "no cpu_ack within 40 cycles");
            void'(exp_q.pop_back());
        end else if (exp_lat > 0) begin
            chk("cpu_latency", n, exp_lat);
        end
        // Keep the request up through the ack cycle's closing edge
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dd", dd, 8'd0);
        chk("rst_cpu_rdata", cpu_rdata, 8'd0);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 13'd0);
        chk("rst_ram_wdata", ram_wdata, 8'd0);
        chk("rst_an_g", an_g, 1'b0);
        chk("rst_css", css, 1'b0);
        chk("rst_gm", gm, 3'd0);
        chk("rst_overrun", vdg_overrun, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Display fetch of a known byte
        vdg_fetch(13'h123);
        chk("dd_c5", dd, 8'hC5);
        chk("an_s_c5", an_s, 1'b1);
        chk("inv_c5", inv, 1'b1);
        @(posedge clk); #1;

        // CPU write and VDG fetch in the same cycle: VDG first
        exp_q.push_back({K_RAMWR, 13'h010, 8'h5A});
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4010; cpu_wdata = 8'h5A;
        vdg_req = 1'b1; vdg_addr = 13'h000;
        for (n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            vdg_req = 1'b0;
            chk("prio_no_ack", cpu_ack, 1'b0);
            chk("prio_no_we", ram_we, 1'b0);
        end
        exp_dd = ref_mem[0];
        chk("prio_dd", dd, exp_dd);
        @(posedge clk); #1;
        chk("prio_ack", cpu_ack, 1'b1);
        chk("prio_we", ram_we, 1'b1);
        chk("prio_addr", ram_addr, 13'h010);
        chk("prio_wdata", ram_wdata, 8'h5A);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        chk("prio_ack_single", cpu_ack, 1'b0);
        chk("prio_we_single", ram_we, 1'b0);
        @(posedge clk); #1;
        vdg_fetch(13'h010);
        chk("dd_5a", dd, 8'h5A);
        cpu_access(1'b0, 16'h4010, 8'h00, 3);

        // Mode latch write, read of the latch address
        cpu_access(1'b1, 16'hBFFF, 8'h74, 1);
        chk("mode_an_g", an_g, 1'b1);
        chk("mode_css", css, 1'b1);
        chk("mode_gm", gm, 3'b101);
        cpu_access(1'b0, 16'hBFFF, 8'h00, 1);

        // Mode write colliding with a VDG request: VDG wins, latch written afterwards
        fork
            vdg_fetch(13'h0AB);
            cpu_access(1'b1, 16'hBFFF, 8'h20, 4);
        join

        // Window boundaries and unmapped space
        cpu_access(1'b0, 16'h8000, 8'h00, 1);
        cpu_access(1'b0, 16'h3FFF, 8'h00, 1);
        cpu_access(1'b0, 16'h6000, 8'h00, 1);
        cpu_access(1'b0, 16'h5FFF, 8'h00, 3);
        cpu_access(1'b1, 16'h2000, 8'h99, 1);
        cpu_access(1'b1, 16'h4000, 8'hE7, 1);
        cpu_access(1'b0, 16'h4000, 8'h00, 3);
        chk("no_overrun_yet", vdg_overrun, 1'b0);

        // Three back-to-back display requests during a CPU read
        fork
            cpu_access(1'b0, 16'h4200, 8'h00, 3);
            begin
                @(posedge clk); #1;
                vdg_req = 1'b1; vdg_addr = 13'h300;
                @(posedge clk); #1;
                vdg_addr = 13'h301;
                @(posedge clk); #1;
                vdg_addr = 13'h302;
                @(posedge clk); #1;
                vdg_req = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk("burst_dd_mid", dd, ref_mem[13'h301]);
                repeat (3) @(posedge clk);
                #1;
                exp_dd = ref_mem[13'h302];
                chk("burst_dd_last", dd, exp_dd);
                chk("burst_overrun", vdg_overrun, 1'b1);
            end
        join
        @(posedge clk); #1;

        // Reset while a CPU read is in its data phase
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4123;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("abort_ack", cpu_ack, 1'b0);
        chk("abort_rdata", cpu_rdata, 8'd0);
        chk("abort_dd", dd, 8'd0);
        chk("abort_ram_addr", ram_addr, 13'd0);
        chk("abort_an_g", an_g, 1'b0);
        chk("abort_overrun", vdg_overrun, 1'b0);
        exp_dd = 8'd0;
        @(posedge clk); #1;
        chk("abort_ack_held", cpu_ack, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ack", cpu_ack, 1'b0);
        cpu_access(1'b0, 16'h4123, 8'h00, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc10_video_fetch.md
MC10_VIDEO_FETCH -- requirements
Module: mc10_video_fetch

Interface
REQ-001 SHALL have parameter RAM_BASE, default 16'h4000, meaning the CPU address of video RAM byte 0; the window is RAM_BASE to RAM_BASE+8191.
REQ-002 SHALL have parameter MODE_ADDR, default 16'hBFFF, meaning the CPU address of the write-only VDG mode latch.
REQ-003 clk  in  1  single system clock; all logic is on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 vdg_req  in  1  one-cycle pulse requesting a display fetch at vdg_addr.
REQ-006 vdg_addr  in  13  VDG video address, sampled on the vdg_req cycle.
REQ-007 cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-008 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-009 cpu_addr  in  16  CPU address; stable while cpu_req is high.
REQ-010 cpu_wdata  in  8  CPU write data.
REQ-011 cpu_rdata  out  8  CPU read data; valid in the cpu_ack cycle.
REQ-012 cpu_ack  out  1  one-cycle completion pulse.
REQ-013 ram_addr  out  13  synchronous single-port RAM address.
REQ-014 ram_we  out  1  RAM write strobe.
REQ-015 ram_wdata  out  8  RAM write data.
REQ-016 ram_rdata  in  8  RAM read data; valid one cycle after the address.
REQ-017 dd  out  8  display byte delivered to the VDG stage.
REQ-018 an_s  out  1  equals dd[7].
REQ-019 inv  out  1  equals dd[6].
REQ-020 an_g, css, gm[2:0]  out  1,1,3  mode latch fields.
REQ-021 vdg_overrun  out  1  sticky flag set when a display fetch is lost.

Function
REQ-022 The FSM SHALL have the states IDLE, VRD_A, VRD_D, CRD_A, CRD_D and CWR, all of which return to IDLE.
REQ-023 From IDLE, a pending or new vdg_req SHALL go to VRD_A; otherwise a RAM-window read SHALL go to CRD_A and a RAM-window write SHALL go to CWR. VDG requests always have priority.
REQ-024 VRD_A SHALL drive ram_addr=vdg_addr with ram_we=0; VRD_D SHALL capture ram_rdata into dd, which makes dd valid 3 clocks after the vdg_req edge when IDLE.
REQ-025 An an_s/inv update SHALL occur in the same cycle as dd, because both are derived from the registered dd.
REQ-026 A vdg_req arriving in a non-IDLE state SHALL set a one-deep pending flag holding its address; a second request while the flag is already set SHALL overwrite the address and set vdg_overrun.
REQ-027 CRD_A SHALL drive ram_addr=cpu_addr-RAM_BASE (low 13 bits); CRD_D SHALL register ram_rdata into cpu_rdata and pulse cpu_ack.
REQ-028 CWR SHALL assert ram_we for one cycle with ram_wdata=cpu_wdata and pulse cpu_ack in the same cycle.
REQ-029 A CPU write to MODE_ADDR SHALL be taken from IDLE in one cycle: an_g=D5, css=D6, gm=D4:D2, cpu_ack pulsed, RAM untouched; a vdg_req in the same cycle SHALL win, and the CPU access is served afterwards.
REQ-030 A CPU read of MODE_ADDR, or any access outside the window and not to MODE_ADDR, SHALL acknowledge in one cycle from IDLE, with cpu_rdata=8'hFF for reads and writes discarded.
REQ-031 cpu_ack SHALL never be asserted on two consecutive cycles, and a held cpu_req SHALL NOT be served twice: one idle cycle follows each ack.
REQ-032 ram_we SHALL be asserted only in CWR.

Reset
REQ-033 On reset_n low, the FSM SHALL go to IDLE and all of the following SHALL be 0: dd, cpu_rdata, cpu_ack, ram_we, ram_addr, ram_wdata, an_g, css, gm, vdg_overrun and the pending flag.
REQ-034 Reset mid-transaction SHALL abort it without ack; after release the CPU re-presents its request.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the default RAM_BASE/MODE_ADDR constants and the mode-bit positions (AN_G=5, CSS=6, GM_LSB=2).
REQ-036 A sub-module, mc10_mode_latch, SHALL hold the register for an_g, css and gm; everything else SHALL be flat.

Verification
REQ-037 RAM[0x123]=8'hC5, vdg_req with vdg_addr=0x123 from IDLE -> dd=C5, an_s=1 and inv=1 three clocks later.
REQ-038 cpu_req write 8'h5A to 0x4010 in the same cycle as vdg_req to 0x0000 -> the VDG read completes first, then ram_we occurs with addr 0x010 and data 5A, and cpu_ack is single-cycle.
REQ-039 A CPU write of 8'h74 to 0xBFFF -> an_g=1, css=1, gm=3'b101, with no ram_we.
REQ-040 Three vdg_req pulses on consecutive cycles during a CPU read -> vdg_overrun=1 and dd=data at the last address; the CPU read still returns correct data.
REQ-041 A CPU read of 0x8000 -> cpu_rdata=FF with an ack one cycle after the request.
REQ-042 Assert reset_n low in CRD_D -> no cpu_ack and all outputs 0; a re-issued read then completes normally.
